calc_sequencer: RTL
===================

# calc_sequencer

Control block for the Basys-3 calculator. It captures the two 2-digit operands and a one-hot operator request, then sequences the arithmetic. Multiply, add and subtract finish in one cycle; divide uses a shared iterative divider. A sequential binary-to-BCD conversion then produces four stable display digits, plus sign and error flags, for the seven-segment mux. It sits between the operand formation/button logic and the display decoder, and replaces free-running combinational `%`/`/` digit extraction with a handshaked pipeline.

## Interface
Parameters:
- OPW, 7: operand width (operands 0..99).
- RESW, 14: result width (max 99*99 = 9801).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- num1  in  OPW  left operand (binary); sampled only on request acceptance.
- num2  in  OPW  right operand; sampled only on request acceptance.
- op_add / op_sub / op_mul / op_div  in  1 each  single-cycle request pulses, already edge-detected upstream.
- clr  in  1  synchronous clear; same effect as rst.
- bcd  out  16  result digits; [15:12] thousands ... [3:0] units.
- neg  out  1  result of a subtraction is negative; bcd holds the magnitude.
- err  out  1  divide by zero.
- op_code  out  2  operator of the displayed result: 0 add, 1 sub, 2 mul, 3 div.
- busy  out  1  computation in progress.
- done  out  1  one-cycle pulse when bcd/neg/err update.

## Operation
- States: IDLE, EXEC, DIV, CONV, SHOW, ERR.
- Request acceptance:
  - Requests are accepted only in IDLE, SHOW or ERR. Pulses in EXEC, DIV or CONV are dropped, not queued.
  - Simultaneous pulses resolve by priority add > sub > mul > div.
- On acceptance: latch num1, num2 and the operator; go to EXEC.
- EXEC (1 cycle) computes a RESW-bit result:
  - add: num1+num2.
  - sub: if num1 >= num2 then num1-num2 with neg_next=0, else num2-num1 with neg_next=1.
  - mul: num1*num2.
  - In all three cases go to CONV.
  - div, num2==0: go to ERR.
  - div, num2!=0: pulse divider start; go to DIV.
- DIV: wait for divider done (exactly 7 cycles after start). Result = zero-extended quotient; remainder discarded (truncating division). Go to CONV.
- CONV: 14-iteration shift-add-3 double-dabble over the RESW-bit result, one iteration per cycle. After 14 cycles go to SHOW.
- Entering SHOW: register bcd, neg and op_code; clear err; pulse done.
- Entering ERR: bcd=16'h0000, neg=0, err=1, op_code=3; pulse done.
- bcd, neg, err and op_code hold their previous values throughout EXEC/DIV/CONV. They change only on SHOW/ERR entry or on reset.
- busy = 1 exactly in EXEC, DIV and CONV.
- rst or clr, in any state including mid-DIV or mid-CONV, on the next edge:
  - state=IDLE.
  - All outputs 0.
  - Divider aborted.
  - Internal operand, result and shift registers cleared.
  - Reset wins over any simultaneous request.

## Timing
- Reset values: bcd=0, neg=0, err=0, op_code=0, busy=0, done=0, state IDLE.
- Request sampled at edge k means:
  - EXEC is the state in the cycle after k; busy is high in that cycle.
- add/sub/mul: CONV occupies cycles k+2..k+15; done=1 in cycle k+16 with new bcd valid.
- div: DIV occupies k+2..k+8; CONV k+9..k+22; done in cycle k+23.
- div by zero: done and err=1 in cycle k+2.
- A request in SHOW or ERR during the done cycle is accepted: that cycle counts as edge k of the new operation.
- Registered outputs only; no combinational path from inputs to outputs.

## Structure
- Shared package calc_pkg:
  - State enum.
  - Op encoding constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3.
  - OPW, RESW, DIV_CYCLES=7, CONV_CYCLES=14.
- Sub-module seq_divider: 7-bit restoring divider.
  - Ports: clk, rst, start, dividend, divisor, quotient, remainder, done.
  - One quotient bit per cycle; done pulses 7 cycles after start.
  - rst aborts it.
- Double-dabble conversion stays inline in calc_sequencer, driven by an iteration counter.

## Test plan
- num1=99, num2=99, op_mul at k -> busy k+1..k+15; done at k+16 with bcd=16'h9801, neg=0, err=0, op_code=2.
- num1=12, num2=45, op_sub -> bcd=16'h0033, neg=1 at k+16; then num1=45, num2=12, op_sub -> bcd=16'h0033, neg=0.
- num1=99, num2=7, op_div -> bcd=16'h0014, done at k+23. Then num1=5, num2=0, op_div -> err=1, bcd=0, done at k+2 of that request.
- op_add and op_div pulsed in the same cycle with num1=50, num2=50 -> op_code=0, bcd=16'h0100. An op_mul pulse during CONV is ignored: exactly one done, result unchanged.
- rst asserted mid-CONV of a mul -> next cycle all outputs 0, state IDLE, no done pulse. A subsequent num1=1, num2=1, op_add completes with bcd=16'h0002 at k+16.
- Back-to-back: new request on the done cycle of the previous result -> accepted; previous bcd held until the second done.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer and its divider.
//   state_t      : sequencer FSM states
//   OP_*         : operator encoding, also driven on op_code
//   OPW / RESW   : operand and binary result widths
//   DIV_CYCLES   : divider latency from start to done
//   CONV_CYCLES  : double-dabble iterations (one per result bit)
package calc_pkg;

    localparam int OPW         = 7;
    localparam int RESW        = 14;
    localparam int DIV_CYCLES  = 7;
    localparam int CONV_CYCLES = 14;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_DIV,
        S_CONV,
        S_SHOW,
        S_ERR
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle.
//   clk, rst          : clock, synchronous active-high abort/reset
//   start             : one-cycle pulse; dividend/divisor sampled here
//   dividend, divisor : unsigned operands (divisor must be non-zero)
//   quotient          : truncated quotient, held after done
//   remainder         : remainder, held after done
//   done              : one-cycle pulse, W cycles after start
module seq_divider
    import calc_pkg::*;
#(
    parameter int W = OPW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    logic [W-1:0]  src_rem, src_quo, src_dvs;
    logic [W:0]    trial;
    logic [W-1:0]  step_rem, step_quo;

    always_comb begin
        // The first bit is resolved on the start edge itself, straight from
        // the inputs, so the last bit lands W cycles after start.
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor : dvs_q;

        trial = {src_rem, src_quo[W-1]};
        if (trial >= {1'b0, src_dvs}) begin
            step_rem = W'(trial - {1'b0, src_dvs});
            step_quo = {src_quo[W-2:0], 1'b1};
        end else begin
            step_rem = trial[W-1:0];
            step_quo = {src_quo[W-2:0], 1'b0};
        end

        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;

        if (start) begin
            rem_d = step_rem;
            quo_d = step_quo;
            dvs_d = divisor;
            cnt_d = CW'(W - 1);
        end else if (cnt_q != '0) begin
            rem_d  = step_rem;
            quo_d  = step_quo;
            cnt_d  = cnt_q - 1'b1;
            done_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control: captures operands and an operator request, computes
// the result (divide through seq_divider), converts it to BCD by sequential
// double-dabble and presents stable digits with sign/error flags.
//   clk, rst, clr          : clock, synchronous active-high reset and clear
//   num1, num2             : binary operands, sampled on request acceptance
//   op_add/sub/mul/div     : single-cycle request pulses
//   bcd, neg, err, op_code : displayed result, updated with done
//   busy, done             : computation in progress / result update pulse
//
// state  | meaning
// IDLE   | nothing shown yet, waiting for a request
// EXEC   | one-cycle arithmetic on the latched operands
// DIV    | waiting for the iterative divider
// CONV   | binary-to-BCD, one bit per cycle
// SHOW   | result displayed, new request may be accepted
// ERR    | divide by zero displayed, new request may be accepted
module calc_sequencer #(
    parameter int OPW  = 7,
    parameter int RESW = 14
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] num1,
    input  logic [OPW-1:0] num2,
    input  logic           op_add,
    input  logic           op_sub,
    input  logic           op_mul,
    input  logic           op_div,
    input  logic           clr,
    output logic [15:0]    bcd,
    output logic           neg,
    output logic           err,
    output logic [1:0]     op_code,
    output logic           busy,
    output logic           done
);

    import calc_pkg::*;

    localparam int DDW = 16 + RESW;

    state_t         state_q, state_d;
    logic [OPW-1:0] num1_q, num1_d, num2_q, num2_d;
    logic [1:0]     op_q, op_d;
    logic           res_neg_q, res_neg_d;
    logic [DDW-1:0] dd_q, dd_d;
    logic [3:0]     conv_cnt_q, conv_cnt_d;
    logic [15:0]    bcd_q, bcd_d;
    logic           neg_q, neg_d, err_q, err_d;
    logic [1:0]     op_code_q, op_code_d;
    logic           busy_q, busy_d, done_q, done_d;

    logic           req_any;
    logic [1:0]     req_op;
    logic [RESW-1:0] a_ext, b_ext, exec_res;
    logic           exec_neg;
    logic [DDW-1:0] dd_step;

    logic           div_start, div_done;
    logic [OPW-1:0] div_quot, div_rem;

    seq_divider #(.W(OPW)) u_div (
        .clk       (clk),
        .rst       (rst | clr),
        .start     (div_start),
        .dividend  (num1_q),
        .divisor   (num2_q),
        .quotient  (div_quot),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_comb begin
        req_any = op_add | op_sub | op_mul | op_div;
        if (op_add)      req_op = OP_ADD;
        else if (op_sub) req_op = OP_SUB;
        else if (op_mul) req_op = OP_MUL;
        else             req_op = OP_DIV;

        a_ext    = RESW'(num1_q);
        b_ext    = RESW'(num2_q);
        exec_neg = 1'b0;
        case (op_q)
            OP_ADD:  exec_res = a_ext + b_ext;
            OP_SUB: begin
                if (a_ext >= b_ext) begin
                    exec_res = a_ext - b_ext;
                end else begin
                    exec_res = b_ext - a_ext;
                    exec_neg = 1'b1;
                end
            end
            default: exec_res = a_ext * b_ext;
        endcase

        // Double-dabble: correct every BCD digit >= 5 by +3, then shift in
        // the next binary bit.
        dd_step = dd_q;
        for (int i = 0; i < 4; i++) begin
            if (dd_step[RESW + 4*i +: 4] >= 4'd5)
                dd_step[RESW + 4*i +: 4] = dd_step[RESW + 4*i +: 4] + 4'd3;
        end
        dd_step = dd_step << 1;
    end

    always_comb begin
        state_d    = state_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        op_d       = op_q;
        res_neg_d  = res_neg_q;
        dd_d       = dd_q;
        conv_cnt_d = conv_cnt_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        err_d      = err_q;
        op_code_d  = op_code_q;
        done_d     = 1'b0;
        div_start  = 1'b0;

        case (state_q)
            S_IDLE, S_SHOW, S_ERR: begin
                if (req_any) begin
                    num1_d  = num1;
                    num2_d  = num2;
                    op_d    = req_op;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_q == OP_DIV) begin
                    if (num2_q == '0) begin
                        state_d   = S_ERR;
                        bcd_d     = '0;
                        neg_d     = 1'b0;
                        err_d     = 1'b1;
                        op_code_d = OP_DIV;
                        done_d    = 1'b1;
                    end else begin
                        div_start = 1'b1;
                        state_d   = S_DIV;
                    end
                end else begin
                    dd_d       = {16'h0000, exec_res};
                    res_neg_d  = exec_neg;
                    conv_cnt_d = 4'(CONV_CYCLES);
                    state_d    = S_CONV;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    dd_d       = {16'h0000, RESW'(div_quot)};
                    res_neg_d  = 1'b0;
                    conv_cnt_d = 4'(CONV_CYCLES);
                    state_d    = S_CONV;
                end
            end
            S_CONV: begin
                dd_d       = dd_step;
                conv_cnt_d = conv_cnt_q - 4'd1;
                if (conv_cnt_q == 4'd1) begin
                    state_d   = S_SHOW;
                    bcd_d     = dd_step[DDW-1 -: 16];
                    neg_d     = res_neg_q;
                    err_d     = 1'b0;
                    op_code_d = op_q;
                    done_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_EXEC) || (state_d == S_DIV) || (state_d == S_CONV);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q    <= S_IDLE;
            num1_q     <= '0;
            num2_q     <= '0;
            op_q       <= OP_ADD;
            res_neg_q  <= 1'b0;
            dd_q       <= '0;
            conv_cnt_q <= '0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
            op_code_q  <= OP_ADD;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            op_q       <= op_d;
            res_neg_q  <= res_neg_d;
            dd_q       <= dd_d;
            conv_cnt_q <= conv_cnt_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            err_q      <= err_d;
            op_code_q  <= op_code_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bcd     = bcd_q;
    assign neg     = neg_q;
    assign err     = err_q;
    assign op_code = op_code_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
